wb_stage_buf: RTL and testbench

- Parametrised writeback stage between mem_wb_reg and the register file.
- Aligns and extends load data by byte offset, with signed/unsigned modes.
- Captures Dcache results that arrive while the pipeline is held (fc_bk) into a BUF_DEPTH-entry in-order buffer. It drains that buffer one entry per cycle once the hold releases, asserting wb_busy_o so fc keeps upstream stalled.

---
 rtl/wb_stage_buf.sv | 155 +++++++++++++++
 tb/tb_wb_stage_buf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buf.sv
// Writeback stage: load alignment/extension plus an in-order capture buffer for
// Dcache results that land while the pipeline is held. Optional counters: WB_PERF_EN.
module wb_stage_buf #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1),
  parameter int OFF_W     = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  memwb_op_c_i,
  input  logic [RA_W-1:0]  memwb_reg_waddr_i,
  input  logic             memwb_reg_we_i,
  input  logic             memwb_mtype_i,
  input  logic [1:0]       memwb_width_i,
  input  logic             memwb_unsigned_i,
  input  logic [OFF_W-1:0] memwb_addr_off_i,
  input  logic [XLEN-1:0]  Dcache_data_i,
  input  logic             fc_Dcache_data_valid_i,
  input  logic             fc_flush_wb_i,
  input  logic             fc_bk_wb_i,
  output logic [XLEN-1:0]  wb_op_c_o,
  output logic [RA_W-1:0]  wb_reg_waddr_o,
  output logic             wb_reg_we_o,
  output logic             wb_busy_o,
  output logic             wb_misalign_o,
  output logic             wb_ovf_o,
  output logic [CNT_W-1:0] wb_buf_cnt_o
`ifdef WB_PERF_EN
  ,
  output logic [31:0]      perf_capt_o,
  output logic [31:0]      perf_drop_o
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0]  raw,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0]       width,
                                                 input logic             uns);
    logic [XLEN-1:0]        sh;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [XLEN-1:0] ext;
    sh  = raw >> {off, 3'b000};
    b   = sh[7:0];
    h   = sh[15:0];
    ext = '0;
    case (width)
      2'b01:   ext = uns ? $signed({{(XLEN-8){1'b0}}, sh[7:0]}) : b;
      2'b10:   ext = uns ? $signed({{(XLEN-16){1'b0}}, sh[15:0]}) : h;
      2'b11:   ext = $signed(raw);
      default: ext = '0;
    endcase
    return ext;
  endfunction

  function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] width);
    return ((width == 2'b10) && off[0]) || ((width == 2'b11) && (off != '0));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [XLEN-1:0]  buf_data [BUF_DEPTH];
  logic [RA_W-1:0]  buf_addr [BUF_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [XLEN-1:0]  aligned;
  logic             mis, load_vld, empty, full, pop, push_req, push_ok, drop;

  assign aligned  = align_load(Dcache_data_i, memwb_addr_off_i, memwb_width_i, memwb_unsigned_i);
  assign mis      = misaligned(memwb_addr_off_i, memwb_width_i);
  assign load_vld = fc_Dcache_data_valid_i & memwb_mtype_i;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(BUF_DEPTH));
  // Drain pops one per cycle; a capture is allowed during hold or alongside a drain.
  assign pop      = !empty && !fc_bk_wb_i;
  assign push_req = load_vld && memwb_reg_we_i && !mis && (fc_bk_wb_i || !empty);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wb_op_c_o      = '0;
    wb_reg_waddr_o = memwb_reg_waddr_i;
    wb_reg_we_o    = 1'b0;
    if (fc_bk_wb_i) begin
      if (!empty) begin
        wb_op_c_o      = buf_data[head];
        wb_reg_waddr_o = buf_addr[head];
      end
    end else if (!empty) begin
      wb_op_c_o      = buf_data[head];
      wb_reg_waddr_o = buf_addr[head];
      wb_reg_we_o    = 1'b1;
    end else if (load_vld) begin
      wb_op_c_o   = aligned;
      wb_reg_we_o = memwb_reg_we_i && !mis;
    end else if (!fc_flush_wb_i) begin
      wb_op_c_o   = memwb_op_c_i;
      wb_reg_we_o = memwb_reg_we_i;
    end
    if (rst) wb_reg_we_o = 1'b0;
  end

  assign wb_busy_o     = !empty && !rst;
  assign wb_misalign_o = load_vld && mis;
  assign wb_ovf_o      = ovf;
  assign wb_buf_cnt_o  = cnt;

  // Buffer storage carries no reset; occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      buf_data[tail] <= aligned;
      buf_addr[tail] <= memwb_reg_waddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      if (push_ok && !pop)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop) cnt <= cnt - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_capt_o <= '0;
      perf_drop_o <= '0;
    end else begin
      if (push_ok) perf_capt_o <= sat_inc(perf_capt_o);
      if (drop)    perf_drop_o <= sat_inc(perf_drop_o);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf (XLEN 32, BUF_DEPTH 2): alignment, hold capture,
// drain order, overflow, flush and reset-mid-drain.
module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_c, dcache;
  logic [4:0]  waddr;
  logic        we, mtype, uns, dvalid, flush, bk;
  logic [1:0]  width;
  logic [1:0]  off;
  logic [31:0] wb_data;
  logic [4:0]  wb_waddr;
  logic        wb_we, busy, misalign, ovf;
  logic [1:0]  cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_buf #(.XLEN(32), .RA_W(5), .BUF_DEPTH(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .memwb_op_c_i           (op_c),
    .memwb_reg_waddr_i      (waddr),
    .memwb_reg_we_i         (we),
    .memwb_mtype_i          (mtype),
    .memwb_width_i          (width),
    .memwb_unsigned_i       (uns),
    .memwb_addr_off_i       (off),
    .Dcache_data_i          (dcache),
    .fc_Dcache_data_valid_i (dvalid),
    .fc_flush_wb_i          (flush),
    .fc_bk_wb_i             (bk),
    .wb_op_c_o              (wb_data),
    .wb_reg_waddr_o         (wb_waddr),
    .wb_reg_we_o            (wb_we),
    .wb_busy_o              (busy),
    .wb_misalign_o          (misalign),
    .wb_ovf_o               (ovf),
    .wb_buf_cnt_o           (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d, input logic [1:0] w,
                      input logic [1:0] o, input logic u);
    dvalid = 1'b1; mtype = 1'b1; we = 1'b1;
    waddr = a; dcache = d; width = w; off = o; uns = u;
  endtask

  task automatic idle;
    dvalid = 1'b0; mtype = 1'b0; we = 1'b0; flush = 1'b0;
    op_c = '0; waddr = '0; dcache = '0; width = 2'b00; off = '0; uns = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    bk  = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    chk("rst_we", wb_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cnt, 2'd0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    tick();

    // Combinational alignment on the empty normal path
    load(5'd7, 32'h80FF_7F01, 2'b01, 2'd3, 1'b0); #1;
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_we", wb_we, 1'b1);
    chk("lb_waddr", wb_waddr, 5'd7);
    uns = 1'b1; #1;
    chk("lbu_data", wb_data, 32'h0000_0080);
    load(5'd3, 32'h8001_1234, 2'b10, 2'd2, 1'b0); #1;
    chk("lh_data", wb_data, 32'hFFFF_8001);
    chk("lh_mis0", misalign, 1'b0);
    off = 2'd1; #1;
    chk("lh_mis1", misalign, 1'b1);
    chk("lh_mis_we", wb_we, 1'b0);
    load(5'd3, 32'hCAFE_F00D, 2'b11, 2'd0, 1'b0); #1;
    chk("lw_data", wb_data, 32'hCAFE_F00D);
    off = 2'd2; #1;
    chk("lw_mis", misalign, 1'b1);
    idle(); op_c = 32'h0000_1234; we = 1'b1; waddr = 5'd4; #1;
    chk("alu_data", wb_data, 32'h0000_1234);
    chk("alu_we", wb_we, 1'b1);
    flush = 1'b1; #1;
    chk("flush_data", wb_data, 32'h0);
    chk("flush_we", wb_we, 1'b0);
    chk("flush_cnt", cnt, 2'd0);

    // Hold capture: two loads, then a third that overflows
    tick();
    idle(); bk = 1'b1;
    load(5'd5, 32'h11, 2'b11, 2'd0, 1'b0); #1;
    chk("hold0_we", wb_we, 1'b0);
    chk("hold0_data", wb_data, 32'h0);
    tick();
    load(5'd6, 32'h22, 2'b11, 2'd0, 1'b0); #1;
    chk("hold1_cnt", cnt, 2'd1);
    chk("hold1_busy", busy, 1'b1);
    chk("hold1_head", wb_data, 32'h11);
    chk("hold1_we", wb_we, 1'b0);
    tick();
    idle(); #1;
    chk("hold2_cnt", cnt, 2'd2);
    chk("hold2_we", wb_we, 1'b0);
    tick();
    load(5'd7, 32'h33, 2'b11, 2'd0, 1'b0); #1;
    chk("hold3_we", wb_we, 1'b0);
    tick();
    idle(); bk = 1'b0; flush = 1'b1; #1;
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_cnt", cnt, 2'd2);
    chk("drain0_we", wb_we, 1'b1);
    chk("drain0_waddr", wb_waddr, 5'd5);
    chk("drain0_data", wb_data, 32'h11);
    chk("drain0_busy", busy, 1'b1);
    tick();
    chk("drain1_we", wb_we, 1'b1);
    chk("drain1_waddr", wb_waddr, 5'd6);
    chk("drain1_data", wb_data, 32'h22);
    chk("drain1_cnt", cnt, 2'd1);
    tick();
    chk("drain2_busy", busy, 1'b0);
    chk("drain2_cnt", cnt, 2'd0);
    chk("drain2_we", wb_we, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);

    // Push and pop in the same drain cycle keep the count steady
    idle(); bk = 1'b1;
    load(5'd8, 32'hAA, 2'b11, 2'd0, 1'b0);
    tick();
    bk = 1'b0;
    load(5'd9, 32'h0000_BB00, 2'b01, 2'd1, 1'b1); #1;
    chk("pp_we", wb_we, 1'b1);
    chk("pp_waddr", wb_waddr, 5'd8);
    chk("pp_data", wb_data, 32'hAA);
    tick();
    idle(); #1;
    chk("pp_cnt", cnt, 2'd1);
    chk("pp_waddr2", wb_waddr, 5'd9);
    chk("pp_data2", wb_data, 32'hBB);
    tick();
    chk("pp_empty", cnt, 2'd0);

    // Reset in the middle of a drain
    bk = 1'b1;
    load(5'd10, 32'h44, 2'b11, 2'd0, 1'b0);
    tick();
    load(5'd11, 32'h55, 2'b11, 2'd0, 1'b0);
    tick();
    idle(); bk = 1'b0; rst = 1'b1; #1;
    chk("rstd_pre_cnt", cnt, 2'd2);
    chk("rstd_we", wb_we, 1'b0);
    chk("rstd_busy", busy, 1'b0);
    tick();
    rst = 1'b0; #1;
    chk("rstd_cnt", cnt, 2'd0);
    chk("rstd_busy2", busy, 1'b0);
    chk("rstd_we2", wb_we, 1'b0);
    chk("rstd_ovf", ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
